// File: rtl/klp32_pkg.sv
// Shared KLP32 definitions: widths, reset defaults and the fetch-queue entry layout.
package klp32_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry synchronous FIFO holding {pc, inst} fetch entries; flush empties it in one cycle.
module fetch_queue2
  import klp32_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_inst_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= '{pc: pc_i, inst: inst_i};
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/inst_fetch32.sv
// KLP32 instruction fetch: owns the PC, fetches from combinational imem into a 2-entry queue,
// and handles redirects, halt and misaligned-target faults.
module inst_fetch32
  import klp32_pkg::*;
#(
  parameter int          XLEN     = klp32_pkg::XLEN,
  parameter logic [31:0] RESET_PC = klp32_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            misalign,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [1:0] DEPTH_C = DEPTH[1:0];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [1:0]      count;
  logic            push, pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready & ~redirect_valid;
  // A full queue can still accept a word in the same cycle its head leaves.
  assign push      = ~halt & ~misalign_q & ~redirect_valid & ((count < DEPTH_C) | pop);

  always_comb begin
    pc_d          = pc_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      misalign_d = (redirect_pc[1:0] != 2'b00);
    end else if (push) begin
      pc_d          = pc_q + 32'd4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_queue2 u_queue (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .pc_i        (pc_q),
    .inst_i      (imem_inst),
    .count_o     (count),
    .head_pc_o   (out_pc),
    .head_inst_o (out_inst)
  );

  assign imem_addr   = pc_q;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch32.sv
// Directed bench for inst_fetch32; instruction memory returns the bitwise inverse of the address.
module tb_inst_fetch32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_inst;
  logic        halt, redirect_valid, out_valid, out_ready, misalign;
  logic [31:0] redirect_pc, out_pc, out_inst, fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_inst = ~imem_addr;

  inst_fetch32 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .misalign       (misalign),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_fc", fetch_count, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    // Streaming with out_ready=1
    step();
    chk("s0_valid", {31'd0, out_valid}, 32'd1);
    chk("s0_pc", out_pc, 32'h0);
    chk("s0_inst", out_inst, 32'hFFFF_FFFF);
    chk("s0_addr", imem_addr, 32'h4);
    step();
    chk("s1_pc", out_pc, 32'h4);
    chk("s1_addr", imem_addr, 32'h8);
    step();
    chk("s2_pc", out_pc, 32'h8);
    chk("s2_inst", out_inst, 32'hFFFF_FFF7);
    chk("s2_fc", fetch_count, 32'd3);

    // Backpressure from a fresh reset
    out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("bp0_pc", out_pc, 32'h0);
    repeat (4) step();
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_fc", fetch_count, 32'd2);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("dr0_pc", out_pc, 32'h4);
    step();
    chk("dr1_pc", out_pc, 32'h8);
    chk("dr1_fc", fetch_count, 32'd4);

    // Redirect with a full queue
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_fc", fetch_count, 32'd4);
    step();
    chk("rd0_valid", {31'd0, out_valid}, 32'd1);
    chk("rd0_pc", out_pc, 32'h100);
    chk("rd0_inst", out_inst, 32'hFFFF_FEFF);
    step();
    chk("rd1_pc", out_pc, 32'h104);
    chk("rd1_fc", fetch_count, 32'd6);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) step();
    chk("mis_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("mis_hold_addr", imem_addr, 32'h102);
    chk("mis_hold_fc", fetch_count, 32'd6);
    chk("mis_hold_flag", {31'd0, misalign}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk("mis_clr", {31'd0, misalign}, 32'd0);
    chk("mis_clr_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("al_pc", out_pc, 32'h200);
    chk("al_fc", fetch_count, 32'd7);

    // Halt with one queued word
    halt = 1'b1;
    step();
    chk("h0_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) step();
    chk("h_addr", imem_addr, 32'h204);
    chk("h_fc", fetch_count, 32'd7);
    chk("h_valid", {31'd0, out_valid}, 32'd0);
    halt = 1'b0;
    step();
    chk("hr_pc", out_pc, 32'h204);
    chk("hr_fc", fetch_count, 32'd8);

    // Wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("w_mis", {31'd0, misalign}, 32'd0);
    step();
    chk("w0_pc", out_pc, 32'hFFFF_FFFC);
    chk("w0_addr", imem_addr, 32'h0);
    step();
    chk("w1_pc", out_pc, 32'h0);
    chk("w1_inst", out_inst, 32'hFFFF_FFFF);
    chk("w1_mis", {31'd0, misalign}, 32'd0);

    // Asynchronous reset mid-stream, checked between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_fc", fetch_count, 32'd0);
    chk("ar_pc", out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch32.md
Name: inst_fetch32

Overview:
Instruction fetch sequencer for the KLP32 core. Owns the program counter and drives the address of the combinational inst_memory32. It buffers fetched words in a 2-entry queue and hands them to decode with a valid/ready handshake. It also handles branch/jump redirects, halt, and misaligned-target faults.

Parameters:
XLEN, 32, data and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, fetch queue entries (fixed at 2; count width is 2 bits)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  XLEN  byte address to inst_memory32 (equals pc_q)
imem_inst  in  XLEN  instruction word returned combinationally for imem_addr
halt  in  1  suppresses new fetches; queue still drains
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  XLEN  redirect target byte address
out_valid  out  1  queue head holds an instruction
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head instruction
out_inst  out  XLEN  head instruction word
misalign  out  1  sticky fault: last redirect target had bit[1:0] != 0
fetch_count  out  XLEN  number of words pushed since reset (perf counter)

Behaviour:
- Reset (async, rst_n=0):
  - pc_q = RESET_PC; queue count = 0; rd/wr pointers = 0; entries = 0.
  - misalign = 0; fetch_count = 0.
  - Outputs: out_valid=0, out_pc=0, out_inst=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all queued words immediately.
- PC and addressing:
  - imem_addr = pc_q, combinational.
  - PC is a byte address and increments by 4 per fetch.
  - 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; no flag is raised.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~halt & ~misalign & ~redirect_valid & (count<2 | pop).
  - On push, {pc_q, imem_inst} is written at wr_ptr, pc_q <= pc_q+4, and fetch_count increments (wraps at 2^32).
- Queue:
  - count' = count + push - pop.
  - Simultaneous push and pop at count=2 is legal and count stays 2.
  - Pop at count=1 with push yields count=1, with the new word at head next cycle.
  - No bypass: a word fetched in cycle N is visible on out_* no earlier than cycle N+1. Fetch-to-decode latency is 1 cycle.
- out_valid = (count != 0). out_pc/out_inst come from the rd_ptr entry and are held stable while out_valid & ~out_ready.
- Redirect (priority over push, pop and halt):
  - count <= 0 and pointers reset, so the queued words are flushed and the head is discarded even if out_ready=1.
  - pc_q <= redirect_pc.
  - If redirect_pc[1:0] != 0: misalign <= 1 and pc_q still loads the target.
  - If redirect_pc[1:0] == 0: misalign <= 0.
  - The first post-redirect fetch occurs the cycle after the redirect.
- Misalign fault: no pushes while misalign=1; the queue drains normally. The fault clears only on an aligned redirect or on reset.
- Halt: no pushes and pc_q holds; pops continue. Deasserting halt resumes fetching at pc_q the same cycle.

Decomposition:
- Shared package klp32_pkg: XLEN, RESET_PC default, INST_NOP = 32'h0000_0013, fetch-entry struct {pc, inst}.
- One sub-module: fetch_queue2, a 2-entry synchronous FIFO with push/pop/flush, count and head outputs. PC/redirect/fault logic stays in inst_fetch32.

Test Plan:
- Reset with out_ready=1 and imem driven by inst_memory32 → imem_addr 0,4,8,... on successive cycles. out_pc sequence 0,4,8 starting 1 cycle after reset release. fetch_count=3 after 3 fetch cycles.
- out_ready=0 for 5 cycles → count saturates at 2 and pc_q stops at 8. out_pc holds 0 until out_ready=1, then 0,4 drain followed by 8.
- Redirect to 32'h0000_0100 while queue is full → out_valid=0 next cycle. Next out_pc=0x100 and the old entries never appear.
- Redirect to 32'h0000_0102 → misalign=1, no further pushes, out_valid=0. A later redirect to 0x200 clears misalign and out_pc=0x200 appears.
- halt=1 for 3 cycles with count=1 → head pops, pc_q frozen, fetch_count unchanged. Release → fetching resumes at the held pc_q.
- Redirect to 32'hFFFF_FFFC → out_pc sequence 0xFFFFFFFC then 0x00000000, misalign=0. Asserting rst_n=0 mid-stream → out_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock.
